spio_hss_multiplexer_retx_store: RTL
====================================

# spio_hss_multiplexer_retx_store

Parametrised go-back-N retransmission packet store for the HSS multiplexer frame assembler. Incoming packets are buffered until the remote end acknowledges them. They are issued to frame issue under remote channel flow control, and rewound for resend on a nak or on an acknowledge timeout. Compared with the fixed-size store it replaces, this block uses the full buffer depth, validates ack/nak windows, reports occupancy, supports a flush and adds timeout-driven retransmission.

## Interface
Parameters:
- PKT_BITS, 72, packet width.
- BUF_BITS, 3, log2 of buffer depth (DEPTH = 2^BUF_BITS); range 1..8.
- SEQ_BITS, 7, frame sequence number width; must exceed BUF_BITS.
- TOUT_CYCLES, 1023, cycles of unacked silence before automatic rewind; 0 disables the timeout.

Ports:
- clk  in  1  clock. One clock domain only.
- rst  in  1  reset. Synchronous and active-high.
- empty  out  1  no unread packet (unacked packets may still be held).
- full  out  1  DEPTH packets held (unacked + unread).
- occupancy  out  BUF_BITS+1  packets held, equal to bw−ba.
- cfc_rem  in  1  remote channel flow control; 1 permits issue.
- vld_ack  in  1  ack valid.
- vld_nak  in  1  nak valid.
- ack_seq  in  SEQ_BITS  first frame NOT acknowledged (ack and nak); on a nak, the frame to resend.
- flush  in  1  discard all held packets.
- pkt_data  in  PKT_BITS  incoming packet.
- pkt_vld  in  1  incoming valid.
- pkt_rdy  out  1  store can accept a packet.
- bpkt_seq  in  SEQ_BITS  sequence number of the frame currently being assembled.
- bpkt_rq  in  1  frame issue requests a packet.
- bpkt_data  out  PKT_BITS  issued packet.
- bpkt_pres  out  1  last request returned a packet.
- bpkt_gt  out  1  grant pulse; bpkt_data valid in this cycle.
- timeout_evt  out  1  one-cycle pulse when the timeout rewind fires.

## Operation
- Pointers ba (oldest unacked), br (next to issue) and bw (next write) are each BUF_BITS+1 bits wide. The MSB is a wrap bit, and addressing uses the low BUF_BITS bits.
- Invariant: ba ≤ br ≤ bw (mod 2^(BUF_BITS+1)), and bw−ba ≤ DEPTH.
- Flags: unread = (br≠bw); empty = !unread; full = (bw−ba == DEPTH). All three are combinational from the registered pointers.
- Write: writing = pkt_vld & pkt_rdy & !flush. On a write, the packet goes to RAM[bw] and bw increments. pkt_rdy is registered as !nxt_full & !flush.
- Issue: reading = bpkt_rq & unread & cfc_rem & !vld_nak & !tout_fire & !flush. On a read:
  - bpkt_data is registered from RAM[br];
  - seq_map[bpkt_seq[BUF_BITS−1:0]] is set to br;
  - br increments.
- bpkt_pres updates only when bpkt_rq is high, taking the value of reading. bpkt_gt is the registered value of reading.
- Ack handling: cand = seq_map[ack_seq[BUF_BITS−1:0]]. If ack_seq == bpkt_seq, cand = br (all outstanding frames are acked).
  - The ack is in window iff (cand−ba) ≤ (br−ba). If it is in window, ba takes cand; otherwise the ack is ignored.
- Nak handling: window check as for the ack. If in window, both ba and br take cand. The nak acks the preceding frames implicitly.
- Timeout: counter tcnt runs while ba≠br. tcnt clears on any vld_ack or vld_nak, when ba==br, or on flush.
  - tout_fire = (tcnt == TOUT_CYCLES−1) & TOUT_CYCLES≠0.
  - When it fires: br takes ba, tcnt clears, and timeout_evt pulses in the next cycle.
- Priority per cycle is flush > nak > timeout > issue for br. An ack and a timeout may coincide; the ack clears tcnt and suppresses tout_fire.
- Flush: ba, br and bw take 0 and tcnt takes 0. RAM and seq_map are untouched; bpkt_pres and bpkt_gt return 0 after one cycle.
- An ack and a write may occur in the same cycle. full and pkt_rdy are computed from the next-state pointers.

## Timing
- Reset values: empty 1, full 0, occupancy 0, pkt_rdy 0, bpkt_data 0, bpkt_pres 0, bpkt_gt 0, timeout_evt 0. Internally, ba, br, bw and tcnt reset to 0.
- pkt_rdy rises one cycle after rst deasserts.
- Write to issue: a packet written in cycle t is readable from cycle t+1. bpkt_gt and bpkt_data follow at t+2 at the earliest.
- Issue latency: bpkt_rq accepted in cycle t gives bpkt_gt and bpkt_data in cycle t+1. Back-to-back issue is allowed every cycle.
- Full: pkt_rdy drops in the cycle after the DEPTH-th write. It rises the cycle after an ack frees an entry.
- Rewind on nak or timeout takes effect in the next cycle. No issue is granted in the rewind cycle itself.
- Reset asserted mid-operation overrides all activity in that cycle.

## Test plan
- Use DEPTH 8. Write 8 packets with no acks → full=1, occupancy=8, and pkt_rdy=0 one cycle after the 8th write. A 9th pkt_vld is not accepted.
- Write 3 packets, then issue with bpkt_seq 0,1,2 → bpkt_gt pulses carry packets 0,1,2 in order. After the third, empty=1 and occupancy=3.
- With 3 frames issued, send a nak with ack_seq=1 → ba=br=1. The next two grants re-issue packets 1 and 2, and occupancy=2.
- Use TOUT_CYCLES=16. Issue 2 frames and send no acks → timeout_evt fires 17 cycles after the first issue. Packets 0 and 1 are then re-issued.
- Send an ack with ack_seq equal to bpkt_seq → occupancy=0 and tcnt stops. A stale out-of-window ack after this leaves ba unchanged.
- Assert flush with 5 packets held → the next cycle shows occupancy=0 and empty=1, and pkt_rdy returns to 1 once flush deasserts. A write in the flush cycle is dropped.

Source files
------------

// File: rtl/spio_hss_multiplexer_retx_store.sv
// Go-back-N retransmission store: buffers packets until acked, issues them under
// remote flow control and rewinds the issue pointer on nak or ack timeout.
module spio_hss_multiplexer_retx_store #(
   parameter int unsigned PKT_BITS    = 72,
   parameter int unsigned BUF_BITS    = 3,
   parameter int unsigned SEQ_BITS    = 7,
   parameter int unsigned TOUT_CYCLES = 1023
) (
   input  logic                clk,
   input  logic                rst,
   output logic                empty,
   output logic                full,
   output logic [BUF_BITS:0]   occupancy,
   input  logic                cfc_rem,
   input  logic                vld_ack,
   input  logic                vld_nak,
   input  logic [SEQ_BITS-1:0] ack_seq,
   input  logic                flush,
   input  logic [PKT_BITS-1:0] pkt_data,
   input  logic                pkt_vld,
   output logic                pkt_rdy,
   input  logic [SEQ_BITS-1:0] bpkt_seq,
   input  logic                bpkt_rq,
   output logic [PKT_BITS-1:0] bpkt_data,
   output logic                bpkt_pres,
   output logic                bpkt_gt,
   output logic                timeout_evt
);

   localparam int unsigned Depth = 1 << BUF_BITS;
   localparam int unsigned PtrW  = BUF_BITS + 1;
   localparam int unsigned CntW  = $clog2(TOUT_CYCLES + 2);
   localparam logic [PtrW-1:0] DepthP = PtrW'(Depth);
   localparam logic [CntW-1:0] TLast  = CntW'((TOUT_CYCLES == 0) ? 0 : TOUT_CYCLES - 1);

   logic [PtrW-1:0]     ba_q, ba_d, br_q, br_d, bw_q, bw_d;
   logic [CntW-1:0]     tcnt_q, tcnt_d;
   logic                pkt_rdy_q, bpkt_pres_q, bpkt_gt_q, tout_evt_q;
   logic [PKT_BITS-1:0] bpkt_data_q;
   logic [PKT_BITS-1:0] ram_q [Depth];
   logic [PtrW-1:0]     seq_map_q [Depth];

   logic            unread, writing, reading, tout_fire, in_win, ack_ok, nak_ok, nxt_full;
   logic [PtrW-1:0] cand, cand_off, br_off, occ_nxt;

   always_comb begin
      unread    = br_q != bw_q;
      writing   = pkt_vld & pkt_rdy_q & ~flush;
      // Acking the frame being assembled means everything issued so far is acked.
      cand      = (ack_seq == bpkt_seq) ? br_q : seq_map_q[ack_seq[BUF_BITS-1:0]];
      cand_off  = cand - ba_q;
      br_off    = br_q - ba_q;
      in_win    = cand_off <= br_off;
      ack_ok    = vld_ack & in_win;
      nak_ok    = vld_nak & in_win;
      tout_fire = (TOUT_CYCLES != 0) && (tcnt_q == TLast) && (ba_q != br_q)
                  && !vld_ack && !vld_nak && !flush;
      reading   = bpkt_rq & unread & cfc_rem & ~vld_nak & ~tout_fire & ~flush;

      ba_d = ba_q;
      br_d = br_q;
      bw_d = bw_q;
      if (writing) bw_d = bw_q + 1'b1;
      if (reading) br_d = br_q + 1'b1;
      if (tout_fire) br_d = ba_q;
      if (ack_ok) ba_d = cand;
      if (nak_ok) begin
         ba_d = cand;
         br_d = cand;
      end
      if (flush) begin
         ba_d = '0;
         br_d = '0;
         bw_d = '0;
      end

      if (flush || vld_ack || vld_nak || (ba_q == br_q) || tout_fire) tcnt_d = '0;
      else tcnt_d = tcnt_q + 1'b1;

      occ_nxt  = bw_d - ba_d;
      nxt_full = occ_nxt == DepthP;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ba_q        <= '0;
         br_q        <= '0;
         bw_q        <= '0;
         tcnt_q      <= '0;
         pkt_rdy_q   <= 1'b0;
         bpkt_data_q <= '0;
         bpkt_pres_q <= 1'b0;
         bpkt_gt_q   <= 1'b0;
         tout_evt_q  <= 1'b0;
      end else begin
         ba_q       <= ba_d;
         br_q       <= br_d;
         bw_q       <= bw_d;
         tcnt_q     <= tcnt_d;
         pkt_rdy_q  <= ~nxt_full & ~flush;
         bpkt_gt_q  <= reading;
         tout_evt_q <= tout_fire;
         if (reading) bpkt_data_q <= ram_q[br_q[BUF_BITS-1:0]];
         if (flush) bpkt_pres_q <= 1'b0;
         else if (bpkt_rq) bpkt_pres_q <= reading;
      end
   end

   // Storage is deliberately not reset; pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (writing) ram_q[bw_q[BUF_BITS-1:0]] <= pkt_data;
         if (reading) seq_map_q[bpkt_seq[BUF_BITS-1:0]] <= br_q;
      end
   end

   assign empty       = ~unread;
   assign occupancy   = bw_q - ba_q;
   assign full        = occupancy == DepthP;
   assign pkt_rdy     = pkt_rdy_q;
   assign bpkt_data   = bpkt_data_q;
   assign bpkt_pres   = bpkt_pres_q;
   assign bpkt_gt     = bpkt_gt_q;
   assign timeout_evt = tout_evt_q;

endmodule
